// File: rtl/obsidian_alu_exec.sv
// Two-stage valid/ready ALU execution wrapper: S1 captures operands, S2 registers
// result, tag, flags {Z,N,C,V} and illegal-opcode error.
module obsidian_alu_exec #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_op,
  input  logic [4:0]       in_shamt,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic [3:0]       out_flags,
  output logic             out_err
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_OR  = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SAL = 4'b0110;
  localparam logic [3:0] OP_SAR = 4'b0111;
  localparam logic [3:0] OP_AND = 4'b1000;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [3:0]       s1_op_q, s1_op_d;
  logic [4:0]       s1_shamt_q, s1_shamt_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_result_q, s2_result_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
  logic [3:0]       s2_flags_q, s2_flags_d;
  logic             s2_err_q, s2_err_d;

  logic s2_can_load, s2_load, in_fire;

  logic [WIDTH-1:0]        res_c;
  logic                    c_c, v_c, err_c;
  logic [WIDTH:0]          add_t, sub_t, sll_t, srl_t;
  logic signed [WIDTH:0]   sar_t;

  // in_ready depends only on pipeline state and out_ready, never on in_valid
  assign s2_can_load = !s2_valid_q || out_ready;
  assign s2_load     = s1_valid_q && s2_can_load;
  assign in_ready    = !s1_valid_q || s2_can_load;
  assign in_fire     = in_valid && in_ready;

  always_comb begin
    res_c = '0;
    c_c   = 1'b0;
    v_c   = 1'b0;
    err_c = 1'b0;
    add_t = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    sub_t = {1'b0, s1_a_q} - {1'b0, s1_b_q};
    // Extra bit past each end catches the last bit shifted out
    sll_t = {1'b0, s1_a_q} << s1_shamt_q;
    srl_t = {s1_a_q, 1'b0} >> s1_shamt_q;
    sar_t = $signed({s1_a_q, 1'b0}) >>> s1_shamt_q;
    case (s1_op_q)
      OP_ADD: begin
        res_c = add_t[WIDTH-1:0];
        c_c   = add_t[WIDTH];
        v_c   = (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1]) && (res_c[WIDTH-1] != s1_a_q[WIDTH-1]);
      end
      OP_SUB: begin
        res_c = sub_t[WIDTH-1:0];
        c_c   = !sub_t[WIDTH];
        v_c   = (s1_a_q[WIDTH-1] != s1_b_q[WIDTH-1]) && (res_c[WIDTH-1] != s1_a_q[WIDTH-1]);
      end
      OP_OR:  res_c = s1_a_q | s1_b_q;
      OP_XOR: res_c = s1_a_q ^ s1_b_q;
      OP_AND: res_c = s1_a_q & s1_b_q;
      OP_SLL, OP_SAL: begin
        res_c = sll_t[WIDTH-1:0];
        c_c   = sll_t[WIDTH];
      end
      OP_SRL: begin
        res_c = srl_t[WIDTH:1];
        c_c   = srl_t[0];
      end
      OP_SAR: begin
        res_c = sar_t[WIDTH:1];
        c_c   = sar_t[0];
      end
      default: err_c = 1'b1;
    endcase
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    s1_shamt_d = s1_shamt_q;
    s1_tag_d   = s1_tag_q;
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_a_d     = in_a;
      s1_b_d     = in_b;
      s1_op_d    = in_op;
      s1_shamt_d = in_shamt;
      s1_tag_d   = in_tag;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    s2_valid_d  = s2_valid_q;
    s2_result_d = s2_result_q;
    s2_tag_d    = s2_tag_q;
    s2_flags_d  = s2_flags_q;
    s2_err_d    = s2_err_q;
    if (s2_load) begin
      s2_valid_d  = 1'b1;
      s2_result_d = res_c;
      s2_tag_d    = s1_tag_q;
      s2_flags_d  = err_c ? 4'b0000 : {(res_c == '0), res_c[WIDTH-1], c_c, v_c};
      s2_err_d    = err_c;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_op_q     <= '0;
      s1_shamt_q  <= '0;
      s1_tag_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_tag_q    <= '0;
      s2_flags_q  <= '0;
      s2_err_q    <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_op_q     <= s1_op_d;
      s1_shamt_q  <= s1_shamt_d;
      s1_tag_q    <= s1_tag_d;
      s2_valid_q  <= s2_valid_d;
      s2_result_q <= s2_result_d;
      s2_tag_q    <= s2_tag_d;
      s2_flags_q  <= s2_flags_d;
      s2_err_q    <= s2_err_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_result = s2_result_q;
  assign out_tag    = s2_tag_q;
  assign out_flags  = s2_flags_q;
  assign out_err    = s2_err_q;

endmodule

// File: tb/tb_obsidian_alu_exec.sv
// Scoreboard bench for obsidian_alu_exec: driver pushes expected results on each
// accepted request, monitor pops and compares on each result transfer.
module tb_obsidian_alu_exec;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, in_ready;
  logic [31:0] in_a, in_b;
  logic [3:0]  in_op;
  logic [4:0]  in_shamt;
  logic [3:0]  in_tag;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_tag;
  logic [3:0]  out_flags;
  logic        out_err;

  obsidian_alu_exec #(.WIDTH(32), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_shamt(in_shamt), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .out_flags(out_flags), .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] r;
    logic [3:0]  tag;
    logic [3:0]  f;
    logic        e;
    int          cyc;
  } exp_t;

  exp_t scb[$];
  int   tests = 0, fails = 0, cyc = 0, acc = 0, outs = 0;
  bit   lat_chk = 0, rand_mode = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, obs, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] sh, input logic [3:0] tag);
    exp_t x;
    logic [63:0] u;
    longint sa, sbv, ss;
    logic c, v;
    int idx;
    x.r = 32'h0; x.e = 1'b0; x.tag = tag; x.cyc = 0;
    c = 1'b0; v = 1'b0;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    case (op)
      4'd0: begin
        u = {32'h0, a} + {32'h0, b}; x.r = u[31:0]; c = u[32];
        ss = sa + sbv; v = (ss != longint'($signed(x.r)));
      end
      4'd1: begin
        x.r = a - b; c = (a >= b);
        ss = sa - sbv; v = (ss != longint'($signed(x.r)));
      end
      4'd2: x.r = a | b;
      4'd3: x.r = a ^ b;
      4'd8: x.r = a & b;
      4'd4, 4'd6: begin
        x.r = a << sh;
        if (sh != 0) begin idx = 32 - int'(sh); c = a[idx]; end
      end
      4'd5, 4'd7: begin
        x.r = a >> sh;
        if (op == 4'd7 && a[31]) x.r = x.r | ~(32'hFFFF_FFFF >> sh);
        if (sh != 0) begin idx = int'(sh) - 1; c = a[idx]; end
      end
      default: x.e = 1'b1;
    endcase
    x.f = x.e ? 4'b0000 : {(x.r == 32'h0), x.r[31], c, v};
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mode) out_ready = ($urandom_range(0, 1) == 1);
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic [3:0] tag, input bit use_exp,
                       input logic [31:0] er, input logic [3:0] ef, input logic ee);
    exp_t x;
    bit ok = 0;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_shamt = sh; in_tag = tag;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      if (ok) begin
        x = model(op, a, b, sh, tag);
        if (use_exp) begin x.r = er; x.f = ef; x.e = ee; end
        x.cyc = cyc;
        scb.push_back(x);
        acc++;
      end
      tick();
    end
    in_valid = 1'b0;
    if (!ok) check("issue_timeout", 0, 1);
  endtask

  task automatic issue_m(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input logic [3:0] tag);
    issue(op, a, b, sh, tag, 1'b0, 32'h0, 4'h0, 1'b0);
  endtask

  task automatic drain();
    rand_mode = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 100 && scb.size() != 0; i++) tick();
    check("drain_empty", 64'(scb.size()), 0);
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (out_valid && out_ready) begin
      outs++;
      if (scb.size() == 0) check("stale_out", 1, 0);
      else begin
        x = scb.pop_front();
        check("result", out_result, x.r);
        check("tag", out_tag, x.tag);
        check("flags", out_flags, x.f);
        check("err", out_err, x.e);
        if (lat_chk) check("latency", 64'(cyc - x.cyc), 2);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] sw_r [0:8];
    logic [3:0]  sw_f [0:8];
    logic [31:0] snap_r, ra, rb;
    logic [3:0]  snap_t;
    int acc0, outs0, c0;

    sw_r = '{32'h0000F22E, 32'h00008790, 32'h0000BDDF, 32'h00008990, 32'h0005E6F8,
             32'h0000179B, 32'h0005E6F8, 32'h0000179B, 32'h0000344F};
    sw_f = '{4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0010, 4'b0000};
    in_valid = 0; in_a = 0; in_b = 0; in_op = 0; in_shamt = 0; in_tag = 0; out_ready = 1;

    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_out_flags", out_flags, 0);
    check("rst_out_err", out_err, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    tick();

    // op sweep, back to back, fixed latency
    lat_chk = 1;
    c0 = cyc;
    for (int op = 0; op < 9; op++)
      issue(4'(op), 32'h0000BCDF, 32'h0000354F, 5'd3, 4'(op), 1'b1, sw_r[op], sw_f[op], 1'b0);
    check("sweep_issue_cycles", 64'(cyc - c0), 9);
    drain();
    lat_chk = 0;

    // flags corner cases, expectations {Z,N,C,V}
    issue(4'd0, 32'h7FFFFFFF, 32'h1, 5'd0, 4'h1, 1'b1, 32'h80000000, 4'b0101, 1'b0);
    issue(4'd1, 32'h0, 32'h1, 5'd0, 4'h2, 1'b1, 32'hFFFFFFFF, 4'b0100, 1'b0);
    issue(4'd0, 32'hFFFFFFFF, 32'h1, 5'd0, 4'h3, 1'b1, 32'h0, 4'b1010, 1'b0);
    issue(4'd7, 32'h80000000, 32'h0, 5'd3, 4'h4, 1'b1, 32'hF0000000, 4'b0100, 1'b0);
    issue(4'b1011, 32'h12345678, 32'h9ABCDEF0, 5'd7, 4'hA, 1'b1, 32'h0, 4'b0000, 1'b1);
    issue_m(4'd0, 32'h00000005, 32'h00000007, 5'd0, 4'hB);
    drain();

    // backpressure: 6 ops with out_ready low for 5 cycles
    out_ready = 1'b0;
    acc0 = acc; outs0 = outs;
    fork
      begin
        for (int i = 0; i < 6; i++)
          issue_m(4'(i), 32'h00F0_0000 + 32'(i * 16'h1111), 32'h0000_0F0F, 5'(i + 1), 4'(i + 1));
      end
      begin
        @(negedge clk); @(negedge clk); @(negedge clk);
        snap_r = out_result; snap_t = out_tag;
        @(negedge clk); @(negedge clk);
        check("bp_accepts", 64'(acc - acc0), 2);
        check("bp_in_ready", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        check("bp_hold_result", out_result, snap_r);
        check("bp_hold_tag", out_tag, snap_t);
        check("bp_first_tag", out_tag, 4'h1);
        @(posedge clk); #1; out_ready = 1'b1;
      end
    join
    drain();
    check("bp_out_count", 64'(outs - outs0), 6);

    // random valid/ready against the model
    rand_mode = 1;
    for (int n = 0; n < 1000; n++) begin
      for (int k = 0; k < 8 && $urandom_range(0, 1) == 1; k++) tick();
      ra = $urandom; rb = $urandom;
      case ($urandom_range(0, 5))
        0: ra = 32'h7FFFFFFF;
        1: ra = 32'h80000000;
        2: rb = 32'hFFFFFFFF;
        3: rb = ra;
        default: ;
      endcase
      issue_m(4'($urandom_range(0, 15)), ra, rb, 5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)));
    end
    drain();
    check("total_out_vs_in", 64'(outs), 64'(acc));

    // reset with two ops in flight
    out_ready = 1'b0;
    issue_m(4'd0, 32'h11, 32'h22, 5'd0, 4'h5);
    issue_m(4'd2, 32'h33, 32'h44, 5'd0, 4'h6);
    #2;
    check("pre_rst_out_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_in_ready", in_ready, 1);
    scb.delete();
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_out_result", out_result, 0);
    check("post_rst_out_tag", out_tag, 0);
    check("post_rst_out_flags", out_flags, 0);
    check("post_rst_out_err", out_err, 0);
    out_ready = 1'b1;
    repeat (5) tick();
    issue_m(4'd3, 32'hA5A5A5A5, 32'h5A5A5A5A, 5'd0, 4'h9);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/obsidian_alu_exec.md
# obsidian_alu_exec

Handshaked, two-stage pipelined execution wrapper around the Obsidian ALU operation set. It accepts one operation per cycle from an issuing master (decode/issue logic or a stimulus sequencer) over a valid/ready channel. It computes the result with status flags and returns it, tagged, over a second valid/ready channel with full backpressure. The block is the responder end of the ALU request interface; the issuer no longer holds operands steady and samples a combinational output.

## Interface
- WIDTH, 32, operand/result width
- TAG_W, 4, width of the request tag echoed with the result
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  request present
- in_ready  out  1  block can accept the request this cycle
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_op  in  4  opcode: 0000 ADD, 0001 SUB, 0010 OR, 0011 XOR, 0100 SLL, 0101 SRL, 0110 SAL, 0111 SAR, 1000 AND
- in_shamt  in  5  shift amount, used by opcodes 0100–0111 only
- in_tag  in  TAG_W  opaque tag returned with the result
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts the result this cycle
- out_result  out  WIDTH  result
- out_tag  out  TAG_W  tag of this result
- out_flags  out  4  {Z, N, C, V}
- out_err  out  1  illegal opcode (1001–1111)

## Operation
- A request transfers on a rising edge when in_valid && in_ready. A result transfers on a rising edge when out_valid && out_ready.
- S1, the operand stage, holds valid, a, b, op, shamt and tag. S2, the output register, holds valid, result, tag, flags and err.
- Compute is combinational from S1 into S2.
- S2 loads when S1 is valid and (!out_valid || out_ready).
- S1 loads on an input transfer.
- in_ready = !s1_valid || s2_can_load. There is no combinational path from in_valid to in_ready.
- Results leave in request order. No request is dropped, duplicated or reordered under any backpressure pattern.
- ADD: result = a+b mod 2^WIDTH. C = carry out. V = signed overflow.
- SUB: result = a−b. C = 1 when no borrow (a >= b unsigned). V = signed overflow.
- OR, XOR, AND: bitwise. C = 0, V = 0.
- SLL and SAL: a << shamt. SRL: logical right shift. SAR: arithmetic right shift, sign bit replicated. Shift ops give C = last bit shifted out (0 when shamt = 0) and V = 0.
- Z = (result == 0). N = result[WIDTH−1]. Both are computed for every legal op.
- Illegal opcode: result = 0, flags = 0000 (Z is forced to 0), out_err = 1. The op is still returned in order with its tag.
- out_result, out_tag, out_flags and out_err are stable while out_valid && !out_ready.

## Timing
- Reset (rst_n low, asynchronous) forces s1_valid = 0 and out_valid = 0.
- During and after reset: in_ready = 1, out_result = 0, out_tag = 0, out_flags = 0, out_err = 0.
- Latency: a request accepted at edge k appears with out_valid = 1 after edge k+1.
- Throughput: one result per cycle while out_ready stays high.
- Stall, out_ready low with S2 full: S1 can still absorb one more request. in_ready then drops after that edge, giving a maximum of 2 requests in flight.
- Release, out_ready high on a full pipe: S2 takes S1 on the same edge, and in_ready is high in that cycle.
- Accept and drain on the same edge are legal in every state.
- Reset asserted mid-operation discards all in-flight operations. The first cycle after rst_n rises behaves as post-reset.

## Test plan
- Basic op sweep, out_ready = 1, A = 0x0000BCDF, B = 0x0000354F, shamt = 3, tags 0..8 for ops 0..8, back to back:
  - ADD gives 0x0000F22E; SUB gives 0x00008790, C = 1; OR gives 0x0000BDDF; XOR gives 0x00008990.
  - SLL and SAL give 0x0005E6F8; SRL gives 0x0000179B; SAR gives 0x0000179B; AND gives 0x0000344F.
  - Each result arrives 2 cycles after its issue cycle with its matching tag, at 1 per cycle.
- Flags:
  - ADD 0x7FFFFFFF+1 gives 0x80000000, N = 1, V = 1, C = 0.
  - SUB 0−1 gives 0xFFFFFFFF, C = 0, N = 1.
  - ADD 0xFFFFFFFF+1 gives 0, Z = 1, C = 1.
  - SAR 0x80000000 by 3 gives 0xF0000000, N = 1.
- Backpressure: issue 6 ops with out_ready held low for 5 cycles.
  - in_ready drops after 2 accepts, and out_* holds steady.
  - On release, all 6 results arrive in order with the correct tags, with no loss or duplication.
- Random stall: random in_valid and out_ready at 50% each, 1000 ops against a reference model. Every result, flag and tag must match, in order.
- Illegal op: in_op = 1011 with tag 0xA gives out_result 0, flags 0000, out_err 1, out_tag 0xA. The next legal op returns out_err 0.
- Reset mid-stream: assert rst_n low with 2 ops in flight.
  - out_valid goes 0 immediately, asynchronously.
  - After release, in_ready = 1 and no stale results appear.
